// File: rtl/key_debounce_pkg.sv
// Shared types and default constants for the push-button conditioner.
// Defaults assume a 50 MHz clock (CLOCK_50).
// cnt_width() gives the counter width needed to hold a given terminal count.
package key_debounce_pkg;

  // Debounce FSM states
  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_e;

  // Default cycle counts at 50 MHz
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 500_000;     // 10 ms
  localparam int unsigned DEF_LONG_CYCLES     = 50_000_000;  // 1 s
  localparam int unsigned DEF_REPEAT_CYCLES   = 10_000_000;  // 200 ms
  localparam int unsigned DEF_CNT_W           = 26;

  // Bits needed to represent values 0..max_count inclusive
  function automatic int unsigned cnt_width(input int unsigned max_count);
    return $clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/key_debounce_if.sv
// Bundle of the raw key input and the conditioned key events.
// master: button/consumer side (drives key, observes events).
// slave : conditioner side (reads key, drives events).
interface key_debounce_if;
  logic key;          // raw button, active-low, asynchronous
  logic key_press;    // 1-cycle pulse on debounced press (and auto-repeat)
  logic key_release;  // 1-cycle pulse on debounced release
  logic key_held;     // debounced level, 1 while pressed
  logic key_long;     // 1-cycle pulse once per press after long hold

  modport master (
    output key,
    input  key_press, key_release, key_held, key_long
  );

  modport slave (
    input  key,
    output key_press, key_release, key_held, key_long
  );
endinterface

// File: rtl/key_debounce_sync_2ff.sv
// Purpose: two-flop synchroniser for one asynchronous level input.
// Latency: 2 clk edges from input sample to q.
// Backpressure: none (free-running level path).
// Ports: clk, reset_n (async active-low), d (async in), q (synchronised out).
module sync_2ff #(
  parameter bit RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;

  always_comb begin
    s1_d = d;
    s2_d = s1_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q <= RESET_VAL;
      s2_q <= RESET_VAL;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/key_debounce.sv
// Purpose: turns one raw active-low push-button into press/release/long pulses and a held level.
// Latency: key stable low from edge E0 -> key_press and key_held at edge E0+2+DEBOUNCE_CYCLES; release symmetric.
// Backpressure: none; pulses are single-cycle and are not held off by the consumer.
// Ports: clk, reset_n (async active-low), bus (key_debounce_if.slave: key in; key_press,
//   key_release, key_held, key_long out).
// Optional feature macro: KEY_REPEAT_EN (auto-repeat key_press every REPEAT_CYCLES after key_long).
module key_debounce
  import key_debounce_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned LONG_CYCLES     = DEF_LONG_CYCLES,
  parameter int unsigned REPEAT_CYCLES   = DEF_REPEAT_CYCLES,
  parameter int unsigned CNT_W           = DEF_CNT_W
) (
  input  logic           clk,
  input  logic           reset_n,
  key_debounce_if.slave  bus
);

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  // Counter parks here once key_long has fired, so it cannot fire again.
  localparam logic [CNT_W-1:0] LONG_TERM = CNT_W'(LONG_CYCLES);
`ifdef KEY_REPEAT_EN
  // After key_long the counter runs LONG_TERM..REP_LAST, one repeat period per lap.
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(LONG_CYCLES + REPEAT_CYCLES - 1);
`else
  logic unused_repeat;
  assign unused_repeat = |REPEAT_CYCLES;
`endif

  logic ks;  // synchronised key level, 0 = pressed

  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (bus.key),
    .q       (ks)
  );

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             long_q, long_d;
  logic             held_q, held_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
      held_q    <= held_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!ks) state_d = PRESS_WAIT;
      end

      PRESS_WAIT: begin
        if (ks) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d = PRESSED;
          cnt_d   = '0;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      PRESSED: begin
        if (ks) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end else if (cnt_q == LONG_LAST) begin
          long_d = 1'b1;
          cnt_d  = LONG_TERM;
`ifdef KEY_REPEAT_EN
        end else if (cnt_q == REP_LAST) begin
          press_d = 1'b1;
          cnt_d   = LONG_TERM;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`else
        end else if (cnt_q != LONG_TERM) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end

      RELEASE_WAIT: begin
        if (!ks) begin
          // Bounce back to pressed: long-hold timing starts over.
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d   = IDLE;
          cnt_d     = '0;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // Level follows the next state so it changes on the same edge as its pulse.
    held_d = (state_d == PRESSED) || (state_d == RELEASE_WAIT);
  end

  assign bus.key_press   = press_q;
  assign bus.key_release = release_q;
  assign bus.key_long    = long_q;
  assign bus.key_held    = held_q;

endmodule

// File: tb/tb_key_debounce.sv
module tb_key_debounce;

  localparam int DEB = 8;
  localparam int LNG = 32;
  localparam int REP = 8;

  logic clk     = 1'b0;
  logic reset_n = 1'b1;

  key_debounce_if kif ();

  key_debounce #(
    .DEBOUNCE_CYCLES (DEB),
    .LONG_CYCLES     (LNG),
    .REPEAT_CYCLES   (REP),
    .CNT_W           (8)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (kif)
  );

  always #5 clk = ~clk;

  // Edge counter: value seen at a negedge is the index of the preceding posedge.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef enum int {EV_PRESS, EV_RELEASE, EV_LONG, EV_RISE, EV_FALL} ev_e;
  typedef struct {
    ev_e kind;
    int  cyc;
  } ev_t;

  ev_t exp_q[$];
  int  tests = 0;
  int  fails = 0;
  logic prev_held = 1'b0;

  function automatic void expect_ev(ev_e k, int c);
    ev_t e;
    e.kind = k;
    e.cyc  = c;
    exp_q.push_back(e);
  endfunction

  function automatic void got(ev_e k, int c);
    ev_t e;
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL unexpected_event: got %s at edge %0d, required no event", k.name(), c);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.cyc != c) begin
        fails++;
        $display("FAIL event_order: got %s at edge %0d, required %s at edge %0d",
                 k.name(), c, e.kind.name(), e.cyc);
      end
    end
  endfunction

  task automatic check(string name, logic act, logic exp_v);
    tests++;
    if (act !== exp_v) begin
      fails++;
      $display("FAIL %s: got %0b, required %0b", name, act, exp_v);
    end
  endtask

  // Monitor: every pulse and every held-level change is matched against the queue.
  always @(negedge clk) begin
    if (kif.key_press)   got(EV_PRESS, cyc);
    if (kif.key_release) got(EV_RELEASE, cyc);
    if (kif.key_long)    got(EV_LONG, cyc);
    if (kif.key_held !== prev_held) begin
      got(kif.key_held ? EV_RISE : EV_FALL, cyc);
      prev_held = kif.key_held;
    end
  end

  // Set key at the negedge before edge e so edge e samples it.
  task automatic drive_at(int e, logic v);
    while (cyc < e - 1) @(negedge clk);
    kif.key = v;
  endtask

  task automatic wait_until(int e);
    while (cyc < e) @(negedge clk);
  endtask

  task automatic check_all_low(string tag);
    check({tag, "_press"},   kif.key_press,   1'b0);
    check({tag, "_release"}, kif.key_release, 1'b0);
    check({tag, "_held"},    kif.key_held,    1'b0);
    check({tag, "_long"},    kif.key_long,    1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, p, r, d, c;
    kif.key = 1'b1;
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    #1 check_all_low("reset");
    @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);

    // Clean press, long hold, then release with bounce.
    e0 = cyc + 1;
    p  = e0 + 2 + DEB;
    expect_ev(EV_PRESS, p);
    expect_ev(EV_RISE, p);
    expect_ev(EV_LONG, p + LNG);
`ifdef KEY_REPEAT_EN
    expect_ev(EV_PRESS, p + LNG + REP);
    expect_ev(EV_PRESS, p + LNG + 2 * REP);
    expect_ev(EV_PRESS, p + LNG + 3 * REP);
`endif
    r = e0 + 70;
    // Bounce: 1,0,1,0 then stable 1 from r+4; release 2+DEB after settling.
    expect_ev(EV_RELEASE, r + 4 + 2 + DEB);
    expect_ev(EV_FALL, r + 4 + 2 + DEB);
    drive_at(e0, 1'b0);
    drive_at(r,     1'b1);
    drive_at(r + 1, 1'b0);
    drive_at(r + 2, 1'b1);
    drive_at(r + 3, 1'b0);
    drive_at(r + 4, 1'b1);
    wait_until(r + 4 + 2 + DEB + 10);

    // Press bounce: toggles every 3 cycles never reach the debounce count.
    e0 = cyc + 1;
    for (int i = 0; i < 14; i++) drive_at(e0 + 3 * i, (i % 2 == 0) ? 1'b0 : 1'b1);
    wait_until(e0 + 42 + 20);

    // Reset while pressed, key kept low, then re-debounce after reset.
    e0 = cyc + 1;
    expect_ev(EV_PRESS, e0 + 2 + DEB);
    expect_ev(EV_RISE, e0 + 2 + DEB);
    drive_at(e0, 1'b0);
    wait_until(e0 + 2 + DEB + 5);
    c = cyc;
    expect_ev(EV_FALL, c + 1);
    #2 reset_n = 1'b0;
    #1 check_all_low("midreset");
    repeat (3) @(negedge clk);
    d = cyc;
    expect_ev(EV_PRESS, d + 1 + 2 + DEB);
    expect_ev(EV_RISE, d + 1 + 2 + DEB);
    reset_n = 1'b1;
    r = d + 1 + 2 + DEB + 10;
    expect_ev(EV_RELEASE, r + 2 + DEB);
    expect_ev(EV_FALL, r + 2 + DEB);
    drive_at(r, 1'b1);
    wait_until(r + 2 + DEB + 10);

    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL missing_events: got %0d events still pending, required 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
